// File: rtl/cordic_log_pkg.sv
// Shared definitions for the CORDIC natural-log controller: FSM encoding,
// hyperbolic repeat schedule and fixed-point constants.
package cordic_log_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Hyperbolic CORDIC only converges if these iterations are issued twice.
   localparam int REP_ITER_A = 4;
   localparam int REP_ITER_B = 13;

   localparam logic [31:0] ONE_Z  = 32'h0100_0000;
   localparam logic [31:0] LN_ERR = 32'h8000_0000;

endpackage

// File: rtl/cordic_hyp_sched.sv
// Step counter for the hyperbolic iteration schedule: maps step index to the
// iteration number (with 4 and 13 repeated) and flags the final step.
module cordic_hyp_sched
   import cordic_log_pkg::*;
#(
   parameter int N_ITER = 24
) (
   input  logic       i_clk,
   input  logic       i_arstn,
   input  logic       i_clear,
   input  logic       i_advance,
   output logic [7:0] o_iter,
   output logic       o_last
);

   localparam int N_STEPS = N_ITER + 2;

   logic [5:0] step_q;
   logic [7:0] step_w;
   logic       past_rep_a;
   logic       past_rep_b;

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         step_q <= '0;
      end else if (i_clear) begin
         step_q <= '0;
      end else if (i_advance) begin
         step_q <= step_q + 6'd1;
      end
   end

   assign step_w = {2'b00, step_q};

   // Once a repeated iteration has been re-issued, every later step lags by one.
   assign past_rep_a = (step_w >= 8'(REP_ITER_A));
   assign past_rep_b = (step_w >= 8'(REP_ITER_B + 1));

   assign o_iter = step_w + 8'd1 - {7'd0, past_rep_a} - {7'd0, past_rep_b};
   assign o_last = (step_q == 6'(N_STEPS - 1));

endmodule

// File: rtl/cordic_log_ctrl.sv
// Sequencer that computes ln(w) = 2*atanh((w-1)/(w+1)) by driving an external
// hyperbolic-vectoring CORDIC core one iteration at a time.
module cordic_log_ctrl
   import cordic_log_pkg::*;
#(
   parameter int WD     = 32,
   parameter int FRAC   = 16,
   parameter int N_ITER = 24
) (
   input  logic              i_clk,
   input  logic              i_arstn,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [WD-1:0]     i_w,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [31:0]       o_ln,
   output logic              o_err,
   output logic              o_core_valid,
   output logic [7:0]        o_core_iter,
   output logic [2*WD-1:0]   o_core_x,
   output logic [2*WD-1:0]   o_core_y,
   output logic [31:0]       o_core_z,
   input  logic              i_core_valid,
   input  logic [2*WD-1:0]   i_core_x1,
   input  logic [2*WD-1:0]   i_core_y1,
   input  logic [31:0]       i_core_z1
);

   localparam int DW = 2 * WD;
   localparam logic [DW-1:0] ONE_W = {{(DW-1){1'b0}}, 1'b1} << FRAC;

   state_t          state_q, state_d;
   logic [DW-1:0]   x_q, y_q;
   logic [31:0]     z_q;
   logic            err_q;
   logic            accept, w_zero;
   logic            load_in, load_core, advance;
   logic            last_step;
   logic [7:0]      sched_iter;
   logic [DW-1:0]   w_ext, x_init, y_init;

   // Aligning w+1 and w-1 high in the wide word leaves headroom for CORDIC growth.
   assign w_ext  = {{WD{1'b0}}, i_w};
   assign x_init = (w_ext + ONE_W) << (WD - 2);
   assign y_init = (w_ext - ONE_W) << (WD - 2);
   assign w_zero = (i_w == '0);

   assign o_ready = (state_q == ST_IDLE) && i_arstn;
   assign accept  = i_valid && o_ready;

   cordic_hyp_sched #(
      .N_ITER (N_ITER)
   ) u_sched (
      .i_clk     (i_clk),
      .i_arstn   (i_arstn),
      .i_clear   (load_in),
      .i_advance (advance),
      .o_iter    (sched_iter),
      .o_last    (last_step)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_d   = state_q;
      load_in   = 1'b0;
      load_core = 1'b0;
      advance   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               load_in = 1'b1;
               state_d = w_zero ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (i_core_valid) begin
               load_core = 1'b1;
               if (last_step) begin
                  state_d = ST_DONE;
               end else begin
                  advance = 1'b1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DONE: begin
            if (i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arstn) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!i_arstn) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_in) begin
            x_q   <= x_init;
            y_q   <= y_init;
            z_q   <= '0;
            err_q <= w_zero;
         end else if (load_core) begin
            x_q <= i_core_x1;
            y_q <= i_core_y1;
            z_q <= i_core_z1;
         end
      end
   end

   assign o_valid      = (state_q == ST_DONE);
   assign o_err        = err_q;
   assign o_ln         = err_q ? LN_ERR : {z_q[30:0], 1'b0};
   assign o_core_valid = (state_q == ST_ISSUE);
   assign o_core_iter  = (state_q == ST_IDLE) ? 8'd0 : sched_iter;
   assign o_core_x     = x_q;
   assign o_core_y     = y_q;
   assign o_core_z     = z_q;

endmodule

// File: tb/tb_cordic_log_ctrl.sv
// Directed bench for cordic_log_ctrl with a two-stage hyperbolic vectoring
// core alongside it; expected logarithms are hand-computed Q8.24 constants.
module tb_cordic_log_ctrl;
   import cordic_log_pkg::*;

   localparam int WD     = 32;
   localparam int N_ITER = 24;
   localparam int N_STEP = N_ITER + 2;
   localparam int LAT    = 3 * N_STEP;

   logic              i_clk   = 1'b0;
   logic              i_arstn = 1'b0;
   logic              i_valid = 1'b0;
   logic              i_ready = 1'b0;
   logic [WD-1:0]     i_w     = '0;
   logic              o_ready, o_valid, o_err, o_core_valid;
   logic [31:0]       o_ln, o_core_z;
   logic [7:0]        o_core_iter;
   logic [2*WD-1:0]   o_core_x, o_core_y;
   logic              i_core_valid;
   logic [2*WD-1:0]   i_core_x1, i_core_y1;
   logic [31:0]       i_core_z1;

   int checks   = 0;
   int failures = 0;
   int exp_iter[$];

   always #5 i_clk = ~i_clk;

   cordic_log_ctrl #(
      .WD     (WD),
      .FRAC   (16),
      .N_ITER (N_ITER)
   ) dut (
      .i_clk        (i_clk),
      .i_arstn      (i_arstn),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_w          (i_w),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_ln         (o_ln),
      .o_err        (o_err),
      .o_core_valid (o_core_valid),
      .o_core_iter  (o_core_iter),
      .o_core_x     (o_core_x),
      .o_core_y     (o_core_y),
      .o_core_z     (o_core_z),
      .i_core_valid (i_core_valid),
      .i_core_x1    (i_core_x1),
      .i_core_y1    (i_core_y1),
      .i_core_z1    (i_core_z1)
   );

   // Iteration core: x/y stage registered on issue, atanh lookup registered a
   // cycle later from the still-held iteration index.
   logic signed [31:0]      atanh_tab [256];
   logic signed [2*WD-1:0]  cx, cy, nx, ny, c1_x, c1_y;
   logic signed [31:0]      c1_z;
   logic                    up, c1_up, c1_v;

   initial begin
      real t;
      for (int i = 0; i < 256; i++) atanh_tab[i] = '0;
      for (int i = 1; i <= 32; i++) begin
         t = 1.0 / (2.0 ** i);
         atanh_tab[i] = $rtoi(0.5 * $ln((1.0 + t) / (1.0 - t)) * real'(ONE_Z) + 0.5);
      end
   end

   assign cx = $signed(o_core_x);
   assign cy = $signed(o_core_y);

   always_comb begin
      up = (cy < 0);
      if (up) begin
         nx = cx + (cy >>> o_core_iter);
         ny = cy + (cx >>> o_core_iter);
      end else begin
         nx = cx - (cy >>> o_core_iter);
         ny = cy - (cx >>> o_core_iter);
      end
   end

   always @(posedge i_clk) begin
      c1_v         <= o_core_valid;
      c1_x         <= nx;
      c1_y         <= ny;
      c1_z         <= $signed(o_core_z);
      c1_up        <= up;
      i_core_valid <= c1_v;
      i_core_x1    <= c1_x;
      i_core_y1    <= c1_y;
      i_core_z1    <= c1_up ? c1_z - atanh_tab[o_core_iter] : c1_z + atanh_tab[o_core_iter];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      longint diff;
      diff = longint'($signed(obs)) - longint'($signed(exp));
      checks++;
      assert (diff >= -64 && diff <= 64)
      else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h (+/-64)", tag, obs, exp);
      end
   endtask

   // Presents w for one accepting edge, then counts edges until o_valid while
   // tracing the issued iteration and issue strobe; noise drives junk i_valid.
   task automatic run_op(input logic [31:0] w, input bit noise, output int lat, output int trace_err);
      lat       = 0;
      trace_err = 0;
      check("ready_before_accept", {63'd0, o_ready}, 64'd1);
      i_w     = w;
      i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      while (o_valid !== 1'b1 && lat < 200) begin
         if (lat < LAT) begin
            if (o_core_iter !== 8'(exp_iter[lat / 3])) trace_err++;
            if (o_core_valid !== (lat % 3 == 0)) trace_err++;
         end
         if (noise) begin
            i_valid = lat[0];
            i_w     = 32'h0003_0000 + 32'(lat);
         end
         @(posedge i_clk); #1;
         lat++;
      end
      i_valid = 1'b0;
   endtask

   task automatic release_result(input string tag);
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      check({tag, "_valid_clr"}, {63'd0, o_valid}, 64'd0);
      check({tag, "_ready_back"}, {63'd0, o_ready}, 64'd1);
   endtask

   task automatic full_op(input string tag, input logic [31:0] w, input logic [31:0] exp_ln, input bit noise);
      int lat, terr;
      run_op(w, noise, lat, terr);
      check({tag, "_latency"}, 64'(lat), 64'(LAT));
      check({tag, "_trace"}, 64'(terr), 64'd0);
      check_near({tag, "_ln"}, o_ln, exp_ln);
      check({tag, "_err"}, {63'd0, o_err}, 64'd0);
      release_result(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, terr, hold_bad;
      logic [31:0] held_ln;

      for (int k = 1; k <= N_ITER; k++) begin
         exp_iter.push_back(k);
         if (k == REP_ITER_A || k == REP_ITER_B) exp_iter.push_back(k);
      end

      repeat (3) @(posedge i_clk);
      #1;
      check("rst_valid", {63'd0, o_valid}, 64'd0);
      check("rst_ready", {63'd0, o_ready}, 64'd0);
      check("rst_ln", {32'd0, o_ln}, 64'd0);
      check("rst_err", {63'd0, o_err}, 64'd0);
      check("rst_core_valid", {63'd0, o_core_valid}, 64'd0);
      check("rst_core_x", o_core_x, 64'd0);
      i_arstn = 1'b1;
      #1;
      check("rst_release_ready", {63'd0, o_ready}, 64'd1);
      @(posedge i_clk); #1;

      full_op("w1p0", 32'h0001_0000, 32'h0000_0000, 1'b0);
      full_op("w2p0", 32'h0002_0000, 32'h00B1_7218, 1'b0);
      full_op("w0p5", 32'h0000_8000, 32'hFF4E_8DE8, 1'b0);
      full_op("w8p0", 32'h0008_0000, 32'h0214_5648, 1'b0);
      full_op("w0p125", 32'h0000_2000, 32'hFDEB_A9B8, 1'b0);

      run_op(32'h0000_0000, 1'b0, lat, terr);
      check("zero_latency", 64'(lat), 64'd0);
      check("zero_err", {63'd0, o_err}, 64'd1);
      check("zero_ln", {32'd0, o_ln}, {32'd0, LN_ERR});
      release_result("zero");

      // Result held in DONE with i_ready low while junk operands are offered.
      run_op(32'h0004_0000, 1'b0, lat, terr);
      check("hold_latency", 64'(lat), 64'(LAT));
      check_near("hold_ln", o_ln, 32'h0162_E430);
      held_ln  = o_ln;
      hold_bad = 0;
      for (int i = 0; i < 10; i++) begin
         i_valid = i[0];
         i_w     = 32'h0000_4000 + 32'(i);
         @(posedge i_clk); #1;
         if (o_valid !== 1'b1 || o_ln !== held_ln || o_err !== 1'b0 || o_ready !== 1'b0) hold_bad++;
      end
      i_valid = 1'b0;
      check("hold_stable", 64'(hold_bad), 64'd0);
      release_result("hold");

      full_op("w2p0_noise", 32'h0002_0000, 32'h00B1_7218, 1'b1);

      // Reset during the wait of step 7; the in-flight core result lands in IDLE.
      i_w     = 32'h0005_0000;
      i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      repeat (22) @(posedge i_clk);
      #1;
      check("mid_iter_before_rst", {56'd0, o_core_iter}, 64'd7);
      i_arstn = 1'b0;
      #1;
      check("mid_rst_valid", {63'd0, o_valid}, 64'd0);
      check("mid_rst_core_valid", {63'd0, o_core_valid}, 64'd0);
      check("mid_rst_core_iter", {56'd0, o_core_iter}, 64'd0);
      check("mid_rst_core_y", o_core_y, 64'd0);
      check("mid_rst_core_z", {32'd0, o_core_z}, 64'd0);
      check("mid_rst_ln", {32'd0, o_ln}, 64'd0);
      #1;
      i_arstn = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      check("post_rst_ready", {63'd0, o_ready}, 64'd1);
      check("post_rst_valid", {63'd0, o_valid}, 64'd0);
      check("post_rst_core_x", o_core_x, 64'd0);
      full_op("after_rst", 32'h0002_0000, 32'h00B1_7218, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
